// File: rtl/fan_output_collector.sv
// fan_output_collector: consumer end of the FAN reduction tree.
// Captures one batch of N-1 partial sums with vector IDs and a valid mask,
// then serializes the valid entries (lowest index first) onto a single
// valid/ready stream, flagging the final entry of each batch.
module fan_output_collector #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int V = 3,
    parameter int S = W + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-2:0][S-1:0]     in_sums,
    input  logic [N-2:0][V-1:0]     in_vec_ids,
    input  logic [N-2:0]            in_valids,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [S-1:0]            out_sum,
    output logic [V-1:0]            out_vec_id,
    output logic [((N-1) > 1 ? $clog2(N-1) : 1)-1:0] out_idx,
    output logic                    out_last
);

    localparam int M     = N - 1;
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    logic [0:0]            state;
    logic [M-1:0]          pending;
    logic [M-1:0][S-1:0]   sums_q;
    logic [M-1:0][V-1:0]   ids_q;

    logic [IDX_W-1:0]      sel;
    logic                  single_left;
    logic                  in_fire;
    logic                  out_fire;

    // Lowest set bit of the pending mask picks the entry to present.
    always_comb begin
        sel = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    // Exactly one pending bit means the presented entry closes the batch.
    always_comb begin
        single_left = (pending != '0) && ((pending & (pending - ONE)) == '0);
    end

    // Handshake decode and output presentation; all zero outside DRAIN.
    always_comb begin
        in_ready   = (state == IDLE);
        in_fire    = in_valid && in_ready;
        out_valid  = (state == DRAIN);
        out_fire   = out_valid && out_ready;
        out_sum    = '0;
        out_vec_id = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        if (state == DRAIN) begin
            out_sum    = sums_q[sel];
            out_vec_id = ids_q[sel];
            out_idx    = sel;
            out_last   = single_left;
        end
    end

    // Control FSM: capture a batch in IDLE, retire one entry per handshake in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        pending <= in_valids;
                        // An all-invalid batch is consumed without leaving IDLE.
                        if (in_valids != '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        pending <= pending & ~(ONE << sel);
                        if (single_left) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

    // Batch storage: loaded only on acceptance, untouched while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sums_q <= '0;
            ids_q  <= '0;
        end else if (in_fire) begin
            sums_q <= in_sums;
            ids_q  <= in_vec_ids;
        end
    end

endmodule

// File: tb/tb_fan_output_collector.sv
// Scoreboard bench for fan_output_collector with directed batches.
module tb_fan_output_collector;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int V     = 3;
    localparam int S     = W + $clog2(N);
    localparam int IDX_W = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N-2:0][S-1:0] in_sums = '0;
    logic [N-2:0][V-1:0] in_vec_ids = '0;
    logic [N-2:0]        in_valids = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [S-1:0]        out_sum;
    logic [V-1:0]        out_vec_id;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [S-1:0]     sum;
        logic [V-1:0]     id;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    fan_output_collector #(.N(N), .W(W), .V(V)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sums    (in_sums),
        .in_vec_ids (in_vec_ids),
        .in_valids  (in_valids),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_vec_id (out_vec_id),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int idx, input int sum, input int id, input int last);
        exp_t e;
        e.idx  = IDX_W'(idx);
        e.sum  = S'(sum);
        e.id   = V'(id);
        e.last = last[0];
        exp_q.push_back(e);
    endtask

    task automatic set_batch(input int s2, input int s1, input int s0,
                             input int i2, input int i1, input int i0,
                             input logic [2:0] vm);
        in_sums[2]    = S'(s2);
        in_sums[1]    = S'(s1);
        in_sums[0]    = S'(s0);
        in_vec_ids[2] = V'(i2);
        in_vec_ids[1] = V'(i1);
        in_vec_ids[0] = V'(i0);
        in_valids     = vm;
        in_valid      = 1'b1;
    endtask

    // Holds in_valid until the collector takes the batch, then drops it.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            bad++;
            total++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the scoreboard to drain and the collector to return to IDLE.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((!in_ready || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, in_ready}, 32'd1);
        chk("queue_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=idx%0d/%0h required=none", out_idx, out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_idx",    {30'd0, out_idx},  {30'd0, e.idx});
                chk("out_sum",    {22'd0, out_sum},  {22'd0, e.sum});
                chk("out_vec_id", {29'd0, out_vec_id}, {29'd0, e.id});
                chk("out_last",   {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum",   {22'd0, out_sum},   32'd0);
        chk("rst_out_id",    {29'd0, out_vec_id}, 32'd0);
        chk("rst_out_idx",   {30'd0, out_idx},   32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sparse batch 101: idx0 then idx2, then back to IDLE
        push(0, 'h10, 1, 0);
        push(2, 'h30, 3, 1);
        set_batch('h30, 'h20, 'h10, 3, 2, 1, 3'b101);
        wait_accept();
        @(negedge clk);
        chk("t1_first_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_in_ready_busy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("t1_second_last", {31'd0, out_last}, 32'd1);
        @(negedge clk);
        chk("t1_ready_again", {31'd0, in_ready}, 32'd1);
        chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        wait_idle();

        // Empty batch: consumed silently
        set_batch('h30, 'h20, 'h10, 3, 2, 1, 3'b000);
        wait_accept();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_no_valid", {31'd0, out_valid}, 32'd0);
            chk("t2_ready",    {31'd0, in_ready},  32'd1);
        end
        wait_idle();

        // Full batch with a 4-cycle stall, plus a blocked second batch
        out_ready = 1'b0;
        push(0, 'h10, 1, 0);
        push(1, 'h20, 2, 0);
        push(2, 'h30, 3, 1);
        push(0, 'h0AA, 6, 1);
        set_batch('h30, 'h20, 'h10, 3, 2, 1, 3'b111);
        wait_accept();
        set_batch('h3CC, 'h0BB, 'h0AA, 4, 5, 6, 3'b001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_stall_idx",   {30'd0, out_idx},   32'd0);
            chk("t3_stall_sum",   {22'd0, out_sum},   32'h10);
            chk("t3_stall_last",  {31'd0, out_last},  32'd0);
            chk("t4_blocked",     {31'd0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_entry_kept", {22'd0, out_sum}, 32'h10);
        wait_accept();
        wait_idle();

        // Reset pulse after the first handshake of batch 110
        push(1, 'h22, 2, 0);
        set_batch('h33, 'h22, 'h11, 3, 2, 1, 3'b110);
        wait_accept();
        @(negedge clk);
        chk("t5_first_idx", {30'd0, out_idx}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_ready", {31'd0, in_ready},  32'd1);
        chk("t5_rst_sum",   {22'd0, out_sum},   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_resume", {31'd0, out_valid}, 32'd0);
        end
        wait_idle();

        // Back-to-back single-entry batches with one bubble between them
        push(1, 'h55, 5, 1);
        push(2, 'h7F, 7, 1);
        set_batch('h00, 'h55, 'h00, 0, 5, 0, 3'b010);
        wait_accept();
        set_batch('h7F, 'h00, 'h00, 7, 0, 0, 3'b100);
        @(negedge clk);
        chk("t6_a_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_a_idx",   {30'd0, out_idx},   32'd1);
        @(negedge clk);
        chk("t6_bubble",  {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_b_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_b_idx",   {30'd0, out_idx},   32'd2);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
